// File: rtl/irq_arbiter.sv
// Platform interrupt arbiter: synchronises, latches, masks and prioritises IRQ lines into a one-hot core flag.
// Optional rotating priority is compiled in with `define IRQ_ARB_ROUND_ROBIN_EN; the default build is fixed lowest-index.
module irq_arbiter #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               int_ack_i,
  input  logic               int_done_i,
  input  logic               we_i,
  input  logic [3:0]         waddr_i,
  input  logic [31:0]        wdata_i,
  input  logic [3:0]         raddr_i,
  output logic [31:0]        rdata_o,
  output logic [7:0]         int_flag_o,
  output logic               busy_o
);

  // state   | meaning
  // IDLE    | no interrupt outstanding; picks a winner when req is nonzero
  // ASSERT  | winner presented on int_flag_o, waiting for core acceptance
  // SERVICE | handler running; waits for int_done_i or matching COMPLETE write
  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    ASSERT  = 3'b010,
    SERVICE = 3'b100
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] irq_s, irq_d_q, rise;
  logic [NUM_SRC-1:0] enable_q, enable_d, type_q, pending_q, pending_d;
  logic [NUM_SRC-1:0] w1c_clr, ack_clr, req;
  logic [NUM_SRC-1:0] flag_q, flag_d;
  logic [2:0]         claim_id_q, claim_id_d, win_idx, ptr_q;
  logic               active_q, active_d, win_found, ack_evt;
  logic               wr_enable, wr_type, wr_pending, complete_hit;
  wire                unused_wdata = ^wdata_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      irq_d_q <= '0;
    end else begin
      sync_q[0] <= irq_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      irq_d_q <= irq_s;
    end
  end

  assign irq_s = sync_q[SYNC_STAGES-1];
  assign rise  = irq_s & ~irq_d_q;

  assign wr_enable    = we_i && (waddr_i == 4'h0);
  assign wr_type      = we_i && (waddr_i == 4'h1);
  assign wr_pending   = we_i && (waddr_i == 4'h2);
  assign complete_hit = we_i && (waddr_i == 4'h4) && (wdata_i[2:0] == claim_id_q);

  assign enable_d = wr_enable ? wdata_i[NUM_SRC-1:0] : enable_q;
  assign w1c_clr  = wr_pending ? (wdata_i[NUM_SRC-1:0] & type_q) : '0;
  // Set dominates any clear on edge sources; level sources just follow the line.
  assign pending_d = (type_q & (rise | (pending_q & ~(w1c_clr | ack_clr)))) | (~type_q & irq_s);
  assign req       = pending_q & enable_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q  <= '0;
      type_q    <= '0;
      pending_q <= '0;
    end else begin
      enable_q  <= enable_d;
      if (wr_type) type_q <= wdata_i[NUM_SRC-1:0];
      pending_q <= pending_d;
    end
  end

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ptr_q <= '0;
    else if (ack_evt) ptr_q <= (claim_id_q == 3'(NUM_SRC-1)) ? 3'd0 : claim_id_q + 3'd1;
  end
`else
  assign ptr_q = 3'd0;
`endif

  // Search starts at the pointer and wraps; with a zero pointer this is plain lowest-index.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = 3'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    flag_d     = flag_q;
    claim_id_d = claim_id_q;
    active_d   = active_q;
    ack_clr    = '0;
    ack_evt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          flag_d     = NUM_SRC'(1) << win_idx;
          claim_id_d = win_idx;
          state_d    = ASSERT;
        end
      end
      ASSERT: begin
        if (int_ack_i) begin
          ack_clr  = (NUM_SRC'(1) << claim_id_q) & type_q;
          ack_evt  = 1'b1;
          flag_d   = '0;
          active_d = 1'b1;
          state_d  = SERVICE;
        end else if (!enable_d[claim_id_q]) begin
          flag_d  = '0;
          state_d = IDLE;
        end
      end
      SERVICE: begin
        flag_d = '0;
        if (int_done_i || complete_hit) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        flag_d   = '0;
        active_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      flag_q     <= '0;
      claim_id_q <= '0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      flag_q     <= flag_d;
      claim_id_q <= claim_id_d;
      active_q   <= active_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      4'h0:    rdata_o = 32'(enable_q);
      4'h1:    rdata_o = 32'(type_q);
      4'h2:    rdata_o = 32'(pending_q);
      4'h3:    rdata_o = {active_q, 28'b0, claim_id_q};
      default: rdata_o = '0;
    endcase
  end

  assign int_flag_o = 8'(flag_q);
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter (default fixed-priority build, NUM_SRC=8, SYNC_STAGES=2).
module tb_irq_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_i;
  logic        int_ack_i, int_done_i, we_i;
  logic [3:0]  waddr_i, raddr_i;
  logic [31:0] wdata_i, rdata_o;
  logic [7:0]  int_flag_o;
  logic        busy_o;
  int          checks = 0;
  int          errors = 0;

  irq_arbiter #(.NUM_SRC(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .int_ack_i(int_ack_i), .int_done_i(int_done_i),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .raddr_i(raddr_i),
    .rdata_o(rdata_o), .int_flag_o(int_flag_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    raddr_i = addr;
    #1;
    chk(tag, rdata_o, exp);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    we_i = 1'b1; waddr_i = addr; wdata_i = data;
    step();
    we_i = 1'b0; waddr_i = '0; wdata_i = '0;
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    irq_i = v;
    step();
    irq_i = '0;
  endtask

  task automatic ack();
    int_ack_i = 1'b1; step(); int_ack_i = 1'b0;
  endtask

  task automatic done();
    int_done_i = 1'b1; step(); int_done_i = 1'b0;
  endtask

  task automatic wait_flag(input string tag, input logic [7:0] exp);
    int n = 0;
    while (int_flag_o == 8'h00 && n < 12) begin
      step();
      n++;
    end
    chk(tag, {24'b0, int_flag_o}, {24'b0, exp});
  endtask

  initial begin
    rst = 1'b0; irq_i = '0; int_ack_i = 0; int_done_i = 0;
    we_i = 0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
    step(3);
    chk("reset_flag", {24'b0, int_flag_o}, 32'h0);
    chk("reset_busy", {31'b0, busy_o}, 32'h0);
    rd("reset_claim", 4'h3, 32'h0);
    rst = 1'b1;
    step();

    // single edge source, exact latency
    wr(4'h0, 32'hFFFF_FF01);
    rd("enable_readback", 4'h0, 32'h0000_0001);
    wr(4'h1, 32'h0000_0001);
    pulse_irq(8'h01);
    step();
    chk("edge_lat_n1", {24'b0, int_flag_o}, 32'h0);
    step();
    chk("edge_lat_n2", {24'b0, int_flag_o}, 32'h0);
    rd("edge_pending", 4'h2, 32'h0000_0001);
    step();
    chk("edge_flag", {24'b0, int_flag_o}, 32'h01);
    chk("edge_busy", {31'b0, busy_o}, 32'h1);
    ack();
    chk("edge_ack_flag", {24'b0, int_flag_o}, 32'h0);
    rd("edge_ack_pending", 4'h2, 32'h0);
    rd("edge_ack_claim", 4'h3, 32'h8000_0000);
    done();
    chk("edge_done_busy", {31'b0, busy_o}, 32'h0);
    rd("edge_done_claim", 4'h3, 32'h0);

    // contention between 5 and 2
    wr(4'h0, 32'hFF);
    wr(4'h1, 32'hFF);
    pulse_irq(8'h24);
    wait_flag("cont_first", 8'h04);
    ack();
    done();
    step();
    chk("cont_second", {24'b0, int_flag_o}, 32'h20);
    ack();
    done();
    rd("cont_pending", 4'h2, 32'h0);

    // masking and W1C
    wr(4'h0, 32'h00);
    pulse_irq(8'h08);
    step(5);
    chk("mask_flag", {24'b0, int_flag_o}, 32'h0);
    chk("mask_busy", {31'b0, busy_o}, 32'h0);
    rd("mask_pending", 4'h2, 32'h08);
    wr(4'h2, 32'h08);
    rd("w1c_pending", 4'h2, 32'h0);
    pulse_irq(8'h08);
    step(4);
    rd("mask_pending2", 4'h2, 32'h08);
    wr(4'h0, 32'h08);
    chk("mask_en_same", {24'b0, int_flag_o}, 32'h0);
    step();
    chk("mask_en_flag", {24'b0, int_flag_o}, 32'h08);
    ack();
    done();
    rd("unmapped_read", 4'h7, 32'h0);

    // level source and withdraw
    wr(4'h1, 32'h00);
    wr(4'h0, 32'h02);
    irq_i = 8'h02;
    wait_flag("level_flag", 8'h02);
    ack();
    chk("level_ack_flag", {24'b0, int_flag_o}, 32'h0);
    done();
    chk("level_done_busy", {31'b0, busy_o}, 32'h0);
    step();
    chk("level_represent", {24'b0, int_flag_o}, 32'h02);
    wr(4'h0, 32'h00);
    chk("withdraw_flag", {24'b0, int_flag_o}, 32'h0);
    chk("withdraw_busy", {31'b0, busy_o}, 32'h0);
    rd("withdraw_pending", 4'h2, 32'h02);
    ack();
    chk("stray_ack_busy", {31'b0, busy_o}, 32'h0);
    irq_i = '0;
    step(3);

    // completion by register write
    wr(4'h1, 32'h40);
    wr(4'h0, 32'h40);
    pulse_irq(8'h40);
    wait_flag("comp_flag", 8'h40);
    rd("comp_claim_assert", 4'h3, 32'h0000_0006);
    done();
    chk("stray_done_busy", {31'b0, busy_o}, 32'h1);
    chk("stray_done_flag", {24'b0, int_flag_o}, 32'h40);
    ack();
    rd("comp_claim_active", 4'h3, 32'h8000_0006);
    wr(4'h4, 32'h5);
    chk("comp_wrong_busy", {31'b0, busy_o}, 32'h1);
    wr(4'h4, 32'h6);
    chk("comp_right_busy", {31'b0, busy_o}, 32'h0);
    rd("comp_right_claim", 4'h3, 32'h0000_0006);

    // asynchronous reset while in SERVICE
    pulse_irq(8'h40);
    wait_flag("rst_pre_flag", 8'h40);
    ack();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_flag", {24'b0, int_flag_o}, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    rd("rst_claim", 4'h3, 32'h0);
    rd("rst_enable", 4'h0, 32'h0);
    step();
    rst = 1'b1;
    step(2);
    chk("post_rst_flag", {24'b0, int_flag_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
